// File: rtl/fir_interp_pacer.sv
// ============================================================================
// Module   : fir_interp_pacer
// Brief    : Circular buffer that absorbs bursty FIR interpolator output and
//            paces it out on a regular request strobe, with prime/run control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_interp_pacer #(
    parameter int DATA_WIDTH  = 17,
    parameter int DEPTH       = 128,
    parameter int PRIME_LEVEL = 64,
    parameter int LWIDTH      = $clog2(DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         data_val_i,
    input  logic                         req_i,
    input  logic                         err_clr_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_val_o,
    output logic        [LWIDTH-1:0]     level_o,
    output logic                         run_o,
    output logic        [1:0]            err_flg_o
);

    localparam int              c_AW          = $clog2(DEPTH);
    localparam logic [LWIDTH-1:0] c_DEPTH     = LWIDTH'(DEPTH);
    localparam logic [LWIDTH-1:0] c_PRIME_LVL = LWIDTH'(PRIME_LEVEL);

    localparam logic [0:0] c_PRIME = 1'b0;
    localparam logic [0:0] c_RUN   = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [c_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LWIDTH-1:0]     level_q, level_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  data_val_q, data_val_d;
    logic [1:0]            err_q, err_d;

    logic rd_en;
    logic wr_en;
    logic overflow;
    logic underrun;

    always_comb begin
        rd_en    = req_i && (state_q == c_RUN) && (level_q != '0);
        underrun = req_i && (state_q == c_RUN) && (level_q == '0);
        // A full buffer still accepts a write when a read frees a slot this cycle.
        wr_en    = data_val_i && ((level_q != c_DEPTH) || rd_en);
        overflow = data_val_i && !wr_en;

        wr_ptr_d = wr_en ? wr_ptr_q + c_AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + c_AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + LWIDTH'(1);
        end else if (!wr_en && rd_en) begin
            level_d = level_q - LWIDTH'(1);
        end

        state_d = state_q;
        if (state_q == c_PRIME) begin
            if (level_d >= c_PRIME_LVL) begin
                state_d = c_RUN;
            end
        end else if (underrun) begin
            state_d = c_PRIME;
        end

        // Priming and underrun requests emit silence rather than stale data.
        data_d = data_q;
        if (req_i) begin
            data_d = rd_en ? mem[rd_ptr_q] : '0;
        end
        data_val_d = req_i;

        err_d[0] = overflow | (err_q[0] & ~err_clr_i);
        err_d[1] = underrun | (err_q[1] & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= c_PRIME;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            data_val_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            data_q     <= data_d;
            data_val_q <= data_val_d;
            err_q      <= err_d;
        end
    end

    assign data_o     = data_q;
    assign data_val_o = data_val_q;
    assign level_o    = level_q;
    assign run_o      = (state_q == c_RUN);
    assign err_flg_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_interp_pacer.sv
// ============================================================================
// Module   : tb_fir_interp_pacer
// Brief    : Directed self-checking bench for fir_interp_pacer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_interp_pacer;

    localparam int c_DW = 17;
    localparam int c_LW = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic signed [c_DW-1:0] data_i = '0;
    logic                   data_val_i = 1'b0;
    logic                   req_i = 1'b0;
    logic                   err_clr_i = 1'b0;
    logic signed [c_DW-1:0] data_o;
    logic                   data_val_o;
    logic [c_LW-1:0]        level_o;
    logic                   run_o;
    logic [1:0]             err_flg_o;

    int n_chk  = 0;
    int n_pass = 0;

    fir_interp_pacer dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .data_val_i (data_val_i),
        .req_i      (req_i),
        .err_clr_i  (err_clr_i),
        .data_o     (data_o),
        .data_val_o (data_val_o),
        .level_o    (level_o),
        .run_o      (run_o),
        .err_flg_o  (err_flg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one rising edge and settle, so outputs reflect that edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        data_val_i = 1'b0;
        req_i      = 1'b0;
        err_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic write_seq(input int first, input int count);
        for (int k = 0; k < count; k++) begin
            data_i     = c_DW'(first + k);
            data_val_i = 1'b1;
            tick();
        end
        data_val_i = 1'b0;
    endtask

    initial begin
        // Reset held with inputs toggling.
        rst_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i     = c_DW'(i + 5);
            data_val_i = i[0];
            req_i      = ~i[0];
            tick();
            chk("rst_outputs", {14'd0, data_o, data_val_o, level_o, run_o, err_flg_o}, 32'd0);
        end
        idle();
        rst_i = 1'b0;
        tick();
        chk("post_rst_outputs", {14'd0, data_o, data_val_o, level_o, run_o, err_flg_o}, 32'd0);

        // Priming output.
        write_seq(1, 10);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        chk("prime_data", data_o, 0);
        chk("prime_val", data_val_o, 1);
        chk("prime_level", level_o, 10);
        chk("prime_err", err_flg_o, 0);
        chk("prime_run", run_o, 0);
        tick();
        chk("prime_val_drop", data_val_o, 0);

        // Prime then read, continuing into underrun.
        do_reset();
        write_seq(1, 63);
        chk("run_before_64", run_o, 0);
        write_seq(64, 1);
        chk("run_after_64", run_o, 1);
        chk("level_64", level_o, 64);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        chk("first_read_data", data_o, 1);
        chk("first_read_val", data_val_o, 1);
        chk("first_read_level", level_o, 63);
        tick();
        chk("hold_data", data_o, 1);
        chk("hold_val", data_val_o, 0);
        req_i = 1'b1;
        for (int k = 2; k <= 64; k++) begin
            tick();
            chk("drain_data", data_o, k);
        end
        chk("drain_level", level_o, 0);
        chk("drain_run", run_o, 1);
        tick();
        req_i = 1'b0;
        chk("underrun_data", data_o, 0);
        chk("underrun_val", data_val_o, 1);
        chk("underrun_err", err_flg_o, 2);
        chk("underrun_run", run_o, 0);
        tick();
        chk("underrun_sticky", err_flg_o, 2);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_cleared", err_flg_o, 0);

        // Overflow, then in-order drain.
        do_reset();
        write_seq(1, 130);
        chk("ovf_level", level_o, 128);
        chk("ovf_err", err_flg_o, 1);
        req_i = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            tick();
            chk("ovf_drain", data_o, k);
        end
        req_i = 1'b0;
        tick();
        chk("ovf_empty", level_o, 0);

        // Full with simultaneous write and read, order kept across the wrap.
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr_before_full", err_flg_o, 0);
        write_seq(1, 128);
        chk("full_level", level_o, 128);
        for (int k = 0; k < 5; k++) begin
            data_i     = c_DW'(131 + k);
            data_val_i = 1'b1;
            req_i      = 1'b1;
            tick();
            chk("simul_data", data_o, k + 1);
            chk("simul_level", level_o, 128);
            chk("simul_err", err_flg_o, 0);
        end
        data_val_i = 1'b0;
        for (int k = 0; k < 128; k++) begin
            tick();
            chk("wrap_drain", data_o, (k < 123) ? k + 6 : 131 + (k - 123));
        end
        req_i = 1'b0;
        tick();
        chk("wrap_empty", level_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_interp_pacer.md
FIR_INTERP_PACER -- requirements
Module: fir_interp_pacer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 17: sample width, equal to the interpolator OUT_WIDTH.
REQ-002 SHALL have parameter DEPTH, default 128: buffer depth in samples; power of two, minimum 4.
REQ-003 SHALL have parameter PRIME_LEVEL, default 64: occupancy required to enter RUN; range 1..DEPTH.
REQ-004 SHALL have parameter LWIDTH, default $clog2(DEPTH)+1: width of the level output.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port data_i, input, DATA_WIDTH bits, signed: interpolated sample from the FIR interpolator.
REQ-008 SHALL have port data_val_i, input, 1 bit: write strobe for data_i; arrives in bursts.
REQ-009 SHALL have port req_i, input, 1 bit: output-rate strobe, one pulse per output sample period.
REQ-010 SHALL have port err_clr_i, input, 1 bit: clears the sticky error flags.
REQ-011 SHALL have port data_o, output, DATA_WIDTH bits, signed: paced output sample.
REQ-012 SHALL have port data_val_o, output, 1 bit: one-cycle strobe marking data_o valid.
REQ-013 SHALL have port level_o, output, LWIDTH bits: current buffer occupancy, 0..DEPTH.
REQ-014 SHALL have port run_o, output, 1 bit: 1 while the FSM is in RUN.
REQ-015 SHALL have port err_flg_o, output, 2 bits: bit0 = overflow (sticky), bit1 = underrun (sticky).

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries with read/write pointers that wrap modulo DEPTH.
REQ-017 A write SHALL occur when data_val_i=1 and either level<DEPTH or a read is performed in the same cycle.
REQ-018 data_val_i=1 with level=DEPTH and no same-cycle read SHALL drop the sample, leave level unchanged and set err_flg_o[0].
REQ-019 FSM states SHALL be PRIME and RUN; reset state is PRIME.
REQ-020 PRIME->RUN SHALL occur on the cycle after level, including that cycle's write, reaches >= PRIME_LEVEL.
REQ-021 In PRIME, req_i SHALL produce data_o=0 and data_val_o=1 one cycle later, with no buffer read and no error.
REQ-022 In RUN, req_i with level>0 SHALL read the oldest sample and present it on data_o with data_val_o=1 exactly one cycle after req_i.
REQ-023 In RUN, req_i with level=0 SHALL output data_o=0 with data_val_o=1, set err_flg_o[1], and move to PRIME; a same-cycle write does not bypass.
REQ-024 Simultaneous write and read SHALL leave level unchanged, including at level=DEPTH, which is not an overflow.
REQ-025 data_o SHALL hold its last value while data_val_o=0; data_val_o SHALL be high only on the cycle after req_i.
REQ-026 Error flags SHALL stay set until err_clr_i=1; if set and clear coincide, set wins.
REQ-027 level_o and run_o SHALL be registered and reflect the state after the current cycle's operations.

Reset
REQ-028 rst_i=1 at any clock edge, including mid-burst, SHALL force: pointers=0, level_o=0, state=PRIME, run_o=0, data_o=0, data_val_o=0, err_flg_o=0.
REQ-029 While rst_i=1, data_val_i and req_i SHALL be ignored; buffer contents need no clearing.

Verification
REQ-030 Reset: assert rst_i 10 cycles with data_val_i/req_i toggling -> all outputs 0 and level_o=0 throughout, and on the cycle after release.
REQ-031 Prime then read: write samples 1..64 with req_i=0 -> run_o=1 after the 64th write; then one req_i pulse -> data_o=1, data_val_o=1 on the next cycle, level_o=63.
REQ-032 Priming output: write 10 samples, pulse req_i -> data_o=0, data_val_o=1, level_o=10, err_flg_o=0, run_o=0.
REQ-033 Overflow: write 130 samples (1..130) with no reads -> level_o=128 and err_flg_o[0]=1; the subsequent 128 reads return 1..128 in order.
REQ-034 Underrun: prime with 64 samples, issue 65 req_i pulses -> 65th returns data_o=0, err_flg_o[1]=1, run_o=0; an err_clr_i pulse then returns err_flg_o to 0.
REQ-035 Full simultaneous access: at level_o=128, assert data_val_i and req_i together for 5 cycles -> level_o stays 128, err_flg_o[0]=0, output order preserved across pointer wrap.
